// File: rtl/rf_wb_scheduler_pkg.sv
// Shared defaults and source encoding for the register-file writeback scheduler.
package rf_wb_scheduler_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_REG_NUM     = 32;
    localparam int DEFAULT_REG_NUM_BIT = 5;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

// File: rtl/rf_wb_scheduler_scoreboard.sv
// Per-register busy scoreboard: set on issue, clear on register-file write,
// with combinational lookups for the issue and the two source operands.
module rf_scoreboard
    import rf_wb_scheduler_pkg::*;
#(
    parameter int REG_NUM     = DEFAULT_REG_NUM,
    parameter int REG_NUM_BIT = DEFAULT_REG_NUM_BIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_en,
    input  logic [REG_NUM_BIT-1:0] set_idx,
    input  logic                   clear_en,
    input  logic [REG_NUM_BIT-1:0] clear_idx,
    input  logic [REG_NUM_BIT-1:0] iss_idx,
    input  logic [REG_NUM_BIT-1:0] rs1_idx,
    input  logic [REG_NUM_BIT-1:0] rs2_idx,
    output logic                   iss_busy,
    output logic                   rs1_busy,
    output logic                   rs2_busy
);

    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_next;

    // Set is applied after clear so a same-index collision resolves to busy.
    always_comb begin
        busy_next = busy;
        if (clear_en) busy_next[clear_idx] = 1'b0;
        if (set_en)   busy_next[set_idx]   = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
            assert (!(set_en && clear_en && set_idx == clear_idx))
                else $error("scoreboard: set and clear of x%0d in one cycle", set_idx);
            assert (!(clear_en && clear_idx != '0 && !busy[clear_idx]))
                else $warning("scoreboard: writeback to x%0d which is not busy", clear_idx);
        end
    end

    assign iss_busy = busy[iss_idx];
    assign rs1_busy = busy[rs1_idx];
    assign rs2_busy = busy[rs2_idx];

endmodule

// File: rtl/rf_wb_scheduler.sv
// Round-robin arbiter between ALU and LSU writebacks onto the single
// register-file write port, plus the RAW/WAW busy scoreboard for decode.
module rf_wb_scheduler
    import rf_wb_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int REG_NUM     = DEFAULT_REG_NUM,
    parameter int REG_NUM_BIT = DEFAULT_REG_NUM_BIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   iss_valid,
    input  logic [REG_NUM_BIT-1:0] iss_rd,
    output logic                   iss_ready,
    input  logic [REG_NUM_BIT-1:0] rs1_addr,
    input  logic [REG_NUM_BIT-1:0] rs2_addr,
    output logic                   raw_stall,
    input  logic                   alu_valid,
    input  logic [REG_NUM_BIT-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]  alu_data,
    output logic                   alu_ready,
    input  logic                   lsu_valid,
    input  logic [REG_NUM_BIT-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]  lsu_data,
    output logic                   lsu_ready,
    output logic                   rf_wen,
    output logic [REG_NUM_BIT-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]  rf_wdata
);

    src_e last_grant;
    logic grant_alu;
    logic grant_lsu;
    logic set_en;
    logic iss_busy;
    logic rs1_busy;
    logic rs2_busy;

    // On a tie the source that did not win last time gets the port.
    always_comb begin
        grant_alu = alu_valid && (!lsu_valid || last_grant == SRC_LSU);
        grant_lsu = lsu_valid && (!alu_valid || last_grant == SRC_ALU);
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_LSU;
        end else if (grant_alu) begin
            last_grant <= SRC_ALU;
        end else if (grant_lsu) begin
            last_grant <= SRC_LSU;
        end
    end

    // x0 writebacks are consumed but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_alu) begin
            rf_wen   <= (alu_rd != '0);
            rf_waddr <= alu_rd;
            rf_wdata <= alu_data;
        end else if (grant_lsu) begin
            rf_wen   <= (lsu_rd != '0);
            rf_waddr <= lsu_rd;
            rf_wdata <= lsu_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    assign iss_ready = (iss_rd == '0) || !iss_busy;
    assign set_en    = iss_valid && iss_ready && (iss_rd != '0);
    assign raw_stall = ((rs1_addr != '0) && rs1_busy) || ((rs2_addr != '0) && rs2_busy);

    rf_scoreboard #(
        .REG_NUM     (REG_NUM),
        .REG_NUM_BIT (REG_NUM_BIT)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (set_en),
        .set_idx   (iss_rd),
        .clear_en  (rf_wen),
        .clear_idx (rf_waddr),
        .iss_idx   (iss_rd),
        .rs1_idx   (rs1_addr),
        .rs2_idx   (rs2_addr),
        .iss_busy  (iss_busy),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
Sequences the single register-file write port between two writeback sources: ALU (single-cycle) and LSU (multi-cycle loads). Keeps a per-register busy scoreboard so decode can stall on RAW/WAW hazards. Sits between execute/memory stages and the register file; drives the register file's wen/waddr/wdata directly.

Parameters:
DATA_WIDTH, 32, width of a register / write data
REG_NUM, 32, number of architectural registers
REG_NUM_BIT, 5, register index width (log2 REG_NUM)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
iss_valid  in  1  decode issuing an instruction that writes rd
iss_rd  in  REG_NUM_BIT  destination of issuing instruction
iss_ready  out  1  issue may proceed (no WAW on iss_rd)
rs1_addr  in  REG_NUM_BIT  decode source 1 index
rs2_addr  in  REG_NUM_BIT  decode source 2 index
raw_stall  out  1  rs1 or rs2 has a pending write
alu_valid  in  1  ALU writeback request
alu_rd  in  REG_NUM_BIT  ALU destination
alu_data  in  DATA_WIDTH  ALU result
alu_ready  out  1  ALU request granted this cycle
lsu_valid  in  1  LSU writeback request
lsu_rd  in  REG_NUM_BIT  LSU destination
lsu_data  in  DATA_WIDTH  load result
lsu_ready  out  1  LSU request granted this cycle
rf_wen  out  1  register-file write enable
rf_waddr  out  REG_NUM_BIT  register-file write index
rf_wdata  out  DATA_WIDTH  register-file write data

Behaviour:
- Reset (rst_n low, async): busy[] all 0, rf_wen 0, rf_waddr 0, rf_wdata 0, last_grant = LSU (so ALU wins first tie). Reset mid-transaction drops any registered write; requesters re-present after reset.
- Handshake: transfer when valid && ready. ready is combinational from valid signals and last_grant; requester holds rd/data stable while valid && !ready.
- Arbitration: only one valid -> grant it. Both valid -> grant the source not in last_grant (round-robin); last_grant updates only on a grant. No starvation: each source waits at most one cycle.
- Write path: grant in cycle N -> rf_wen=1, rf_waddr/rf_wdata = granted rd/data in cycle N+1 (registered, 1-cycle latency). No grant -> rf_wen=0 next cycle, rf_waddr/rf_wdata hold.
- rd==0 writeback: accepted (ready asserted per arbitration) but rf_wen stays 0; scoreboard unaffected.
- Scoreboard set: iss_valid && iss_ready && iss_rd!=0 -> busy[iss_rd]=1 at end of cycle.
- Scoreboard clear: busy[rf_waddr]=0 at the edge ending a cycle with rf_wen=1 (same edge the register file writes), so a reader in the following cycle sees the new value combinationally.
- iss_ready = (iss_rd==0) || !busy[iss_rd]; independent of iss_valid.
- raw_stall = (rs1_addr!=0 && busy[rs1_addr]) || (rs2_addr!=0 && busy[rs2_addr]); purely combinational on current busy[] (no bypass).
- Set and clear of the same index in one cycle cannot occur (set requires !busy, clear requires busy); if it does, set wins and a simulation assertion fires.
- Writeback to a register not busy (and rd!=0): written normally, assertion warns (scoreboard protocol error).
- busy[0] is constant 0.

Decomposition:
- Shared package: DATA_WIDTH/REG_NUM/REG_NUM_BIT defaults, source encoding constants SRC_ALU=0, SRC_LSU=1.
- One natural sub-module: rf_scoreboard (busy vector, set/clear ports, three combinational lookups). The arbiter and write register stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with alu_valid=1 -> rf_wen=0, rf_waddr=0, rf_wdata=0 immediately; iss_ready=1 for any rd.
- Single ALU write: issue rd=5, next cycle alu_valid rd=5 data=0xDEADBEEF -> alu_ready=1, next cycle rf_wen=1 waddr=5 wdata=0xDEADBEEF; raw_stall for rs1=5 is 1 until the cycle after rf_wen, then 0.
- Contention: alu (rd=3, 0x11) and lsu (rd=4, 0x22) valid together for 2 cycles from reset -> ALU granted first, LSU second; rf writes x3=0x11 then x4=0x22 on consecutive cycles.
- Round-robin: both valid continuously with new data each grant for 6 cycles -> grants alternate ALU/LSU, neither source waits more than 1 cycle.
- WAW: issue rd=7, then iss_valid rd=7 -> iss_ready=0 until the cycle after rf_wen for x7, then 1.
- x0: issue rd=0 and alu writeback rd=0 data=0xFFFFFFFF -> iss_ready=1, alu_ready=1, rf_wen stays 0, raw_stall for rs1=0 stays 0.
